hazard_scoreboard: RTL and testbench

Parametrised hazard-detection and forwarding controller for the WISC pipeline. Sits beside the ID stage and tracks every in-flight register write from EX through WB in an internal shift scoreboard. Each cycle it produces per-operand forwarding selects, a load-use stall, and IF/ID and ID/EX flush strobes on a taken redirect. It also keeps saturating stall and flush event counters for performance visibility.

---
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_hazard_scoreboard.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard-detection and forwarding controller for the WISC pipeline.
// Tracks in-flight register writes EX..WB and derives forwarding selects, load-use stall and redirect flushes.
module hazard_scoreboard #(
  parameter int REG_W      = 4,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [DEPTH:1]   v_q, v_d;
  logic [DEPTH:1]   ld_q;
  logic [REG_W-1:0] rd_q [1:DEPTH];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             haz_a, haz_b;
  logic             issue;

  // Scans oldest to youngest so the youngest matching stage overwrites the result.
  function automatic void lookup(input logic [REG_W-1:0] src, input logic en,
                                 output logic [SEL_W-1:0] sel, output logic haz);
    sel = '0;
    haz = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (en && v_q[k] && (rd_q[k] == src)) begin
        sel = SEL_W'(k);
        haz = ld_q[k] && (k < LOAD_STAGE);
      end
    end
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    haz_a     = 1'b0;
    haz_b     = 1'b0;
    lookup(id_rs, id_valid && id_rs_used && (id_rs != '0), fwd_a_sel, haz_a);
    lookup(id_rt, id_valid && id_rt_used && (id_rt != '0), fwd_b_sel, haz_b);
  end

  // Redirect wins over load-use: the ID instruction is squashed, so there is nothing to hold.
  assign stall      = (haz_a || haz_b) && !ex_redirect;
  assign flush_ifid = ex_redirect;
  assign flush_idex = ex_redirect;
  assign issue      = id_valid && id_wr && (id_rd != '0) && !stall && !ex_redirect;

  always_comb begin
    v_d    = '0;
    v_d[1] = issue;
    for (int k = 2; k <= DEPTH; k++) begin
      v_d[k] = v_q[k-1];
    end
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ex_redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      v_q         <= v_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // NOTE: rd/ld payload has no reset; it is never consulted while its valid bit is clear.
  always_ff @(posedge clk) begin
    rd_q[1] <= id_rd;
    ld_q[1] <= id_is_load;
    for (int k = 2; k <= DEPTH; k++) begin
      rd_q[k] <= rd_q[k-1];
      ld_q[k] <= ld_q[k-1];
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a queue-based in-flight write model.
module tb_hazard_scoreboard;
  localparam int REG_W      = 4;
  localparam int DEPTH      = 3;
  localparam int LOAD_STAGE = 2;
  localparam int CNT_W      = 4;
  localparam int SEL_W      = $clog2(DEPTH + 1);
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk, rst;
  logic             id_valid, id_rs_used, id_rt_used, id_wr, id_is_load, ex_redirect;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             stall, flush_ifid, flush_idex;
  logic [SEL_W-1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_scoreboard #(.REG_W(REG_W), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall(stall),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: element i of the queue is the write sitting at stage i+1.
  typedef struct { bit v; int rd; bit ld; } entry_t;
  entry_t pipe[$];
  int     m_stall_cnt, m_flush_cnt;
  bit     m_stall;
  int     pass_cnt, total_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic void model_src(input bit v, input int s, input bit used,
                                    output int sel, output bit haz);
    sel = 0;
    haz = 1'b0;
    if (v && used && s != 0) begin
      for (int k = 1; k <= pipe.size(); k++) begin
        if (pipe[k-1].v && pipe[k-1].rd == s) begin
          sel = k;
          haz = pipe[k-1].ld && (k < LOAD_STAGE);
          break;
        end
      end
    end
  endfunction

  task automatic model_clear();
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back('{v: 1'b0, rd: 0, ld: 1'b0});
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // One ID cycle: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic drive(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                       input int rd, input bit wr, input bit ld, input bit redir);
    int sa, sb;
    bit ha, hb;
    id_valid = v; id_rs = REG_W'(rs); id_rt = REG_W'(rt);
    id_rs_used = rsu; id_rt_used = rtu; id_rd = REG_W'(rd);
    id_wr = wr; id_is_load = ld; ex_redirect = redir;
    #1;
    model_src(v, rs, rsu, sa, ha);
    model_src(v, rt, rtu, sb, hb);
    m_stall = (ha || hb) && !redir;
    check("stall", 32'(stall), 32'(m_stall));
    check("flush_ifid", 32'(flush_ifid), 32'(redir));
    check("flush_idex", 32'(flush_idex), 32'(redir));
    if (!m_stall) begin
      check("fwd_a_sel", 32'(fwd_a_sel), 32'(sa));
      check("fwd_b_sel", 32'(fwd_b_sel), 32'(sb));
    end
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
    @(posedge clk);
    if (m_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (redir && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    pipe.push_front('{v: v && wr && rd != 0 && !m_stall && !redir, rd: rd, ld: ld});
    void'(pipe.pop_back());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt = 0; total_cnt = 0;
    model_clear();
    rst = 1'b0;
    {id_valid, id_rs_used, id_rt_used, id_wr, id_is_load, ex_redirect} = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_fwd_a", 32'(fwd_a_sel), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_flush_cnt", 32'(flush_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    // Fill with loads, present a dependent op, then assert reset mid-stall.
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    id_valid = 1; id_rs = 4'd7; id_rt = 4'd6; id_rs_used = 1; id_rt_used = 1;
    id_rd = 4'd8; id_wr = 1; id_is_load = 0; ex_redirect = 0;
    #1;
    check("pre_rst_stall", 32'(stall), 1);
    rst = 1'b0;
    #1;
    model_clear();
    check("mid_rst_stall", 32'(stall), 0);
    check("mid_rst_fwd_a", 32'(fwd_a_sel), 0);
    check("mid_rst_fwd_b", 32'(fwd_b_sel), 0);
    check("mid_rst_flush", 32'(flush_ifid), 0);
    check("mid_rst_stall_cnt", 32'(stall_cnt), 0);
    check("mid_rst_flush_cnt", 32'(flush_cnt), 0);
    id_valid = 0;
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);

    drive(1, 1, 2, 1, 1, 3, 1, 0, 0);   // ADD R3
    drive(1, 3, 3, 1, 1, 4, 1, 0, 0);   // ADD R4,R3,R3 -> fwd 1/1
    idle(3);
    drive(1, 1, 2, 1, 1, 5, 1, 1, 0);   // LW R5
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0);   // ADD R6,R5,R1 stalls
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0);   // then forwards from stage 2
    idle(3);
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
    drive(1, 2, 2, 1, 1, 7, 1, 0, 0);   // youngest R2 -> 1
    idle(3);
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
    idle(1);
    drive(1, 2, 2, 1, 1, 7, 1, 0, 0);   // R2 at stages 2,3 -> 2
    idle(3);
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
    idle(2);
    drive(1, 2, 2, 1, 1, 7, 1, 0, 0);   // R2 at stage 3 -> 3
    idle(3);
    drive(1, 1, 1, 1, 1, 0, 1, 0, 0);   // ADD R0
    drive(1, 0, 0, 1, 1, 1, 1, 0, 0);   // ADD R1,R0,R0
    idle(3);
    drive(1, 1, 1, 1, 1, 5, 1, 1, 0);   // LW R5
    drive(1, 5, 5, 1, 1, 9, 1, 0, 1);   // dependent + redirect: squashed
    drive(1, 9, 9, 1, 1, 10, 1, 0, 0);  // R9 never matches

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end

    for (int i = 0; i < 20; i++) drive(1, 1, 2, 1, 1, 3, 1, 0, 1);
    #1;
    check("flush_sat", 32'(flush_cnt), 32'(CNT_MAX));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
